// File: rtl/i2c_bus_sniffer_pkg.sv
// Shared event codes and decoder state encodings for the passive I2C bus sniffer.
package i2c_sniff_pkg;

    typedef enum logic [1:0] {
        EV_START   = 2'd0,
        EV_RESTART = 2'd1,
        EV_STOP    = 2'd2,
        EV_BYTE    = 2'd3
    } ev_type_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        ACK  = 2'd2
    } sniff_state_e;

endpackage

// File: rtl/i2c_bus_sniffer_if.sv
// Pin taps plus the event stream handshake between the sniffer and its consumer.
interface i2c_bus_sniffer_if;
    import i2c_sniff_pkg::*;

    logic       scl_in;
    logic       sda_in;
    logic       ev_valid;
    logic       ev_ready;
    ev_type_e   ev_type;
    logic [7:0] ev_data;
    logic       ev_ack;
    logic       ev_first;
    logic       overflow;
    logic       frame_err;
    logic       busy;

    modport master (
        input  scl_in, sda_in, ev_ready,
        output ev_valid, ev_type, ev_data, ev_ack, ev_first, overflow, frame_err, busy
    );

    modport slave (
        output scl_in, sda_in, ev_ready,
        input  ev_valid, ev_type, ev_data, ev_ack, ev_first, overflow, frame_err, busy
    );
endinterface

// File: rtl/i2c_bus_sniffer_line_filter.sv
// Two-flop synchroniser followed by a stability counter; the output only follows the
// pin after it has held a new level for FILTER_LEN consecutive cycles.
module i2c_line_filter #(
    parameter int FILTER_LEN = 4,
    parameter int CNT_W      = 4
) (
    input  logic ICE_CLK,
    input  logic rst,
    input  logic line_in,
    output logic line_out
);

    logic             sync1_r;
    logic             sync2_r;
    logic             filt_r;
    logic [CNT_W-1:0] cnt_r;

    // Synchronise the raw pin and debounce it against the current filtered level.
    always_ff @(posedge ICE_CLK) begin
        if (rst) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            filt_r  <= 1'b1;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            sync1_r <= line_in;
            sync2_r <= sync1_r;
            if (sync2_r != filt_r) begin
                if (cnt_r == CNT_W'(FILTER_LEN - 1)) begin
                    filt_r <= sync2_r;
                    cnt_r  <= {CNT_W{1'b0}};
                end else begin
                    cnt_r <= cnt_r + CNT_W'(1);
                end
            end else begin
                cnt_r <= {CNT_W{1'b0}};
            end
        end
    end

    assign line_out = filt_r;

endmodule

// File: rtl/i2c_bus_sniffer.sv
// Passive I2C decoder: filters the tapped SCL/SDA pins and emits START/RESTART/STOP/BYTE
// events on a valid/ready stream. Never drives the bus.
module i2c_bus_sniffer
    import i2c_sniff_pkg::*;
#(
    parameter int FILTER_LEN = 4,
    parameter int CNT_W      = 4
) (
    input  logic              ICE_CLK,
    input  logic              rst,
    i2c_bus_sniffer_if.master bus
);

    logic         scl_f_s;
    logic         sda_f_s;
    logic         scl_prev_r;
    logic         sda_prev_r;
    logic         scl_rise_s;
    logic         scl_fall_s;
    logic         start_s;
    logic         stop_s;

    sniff_state_e state_r;
    logic [2:0]   bit_cnt_r;
    logic         bit_pend_r;
    logic [7:0]   shreg_r;
    logic         first_r;

    logic         ev_fire_s;
    ev_type_e     ev_kind_s;
    logic [7:0]   ev_byte_s;
    logic         ev_ack_s;
    logic         ev_first_s;
    logic         frame_bad_s;
    logic         frame_set_s;

    logic         ev_valid_r;
    ev_type_e     ev_type_r;
    logic [7:0]   ev_data_r;
    logic         ev_ack_r;
    logic         ev_first_r;
    logic         overflow_r;
    logic         frame_err_r;
    logic         busy_r;

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN), .CNT_W(CNT_W)) u_scl_filter (
        .ICE_CLK  (ICE_CLK),
        .rst      (rst),
        .line_in  (bus.scl_in),
        .line_out (scl_f_s)
    );

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN), .CNT_W(CNT_W)) u_sda_filter (
        .ICE_CLK  (ICE_CLK),
        .rst      (rst),
        .line_in  (bus.sda_in),
        .line_out (sda_f_s)
    );

    // Bus conditions; requiring SCL high in both cycles lets a simultaneous SCL edge win.
    assign scl_rise_s = scl_f_s & ~scl_prev_r;
    assign scl_fall_s = ~scl_f_s & scl_prev_r;
    assign start_s    = scl_f_s & scl_prev_r & sda_prev_r & ~sda_f_s;
    assign stop_s     = scl_f_s & scl_prev_r & ~sda_prev_r & sda_f_s;

    // The SCL rise that precedes a STOP/RESTART is not a completed data bit, so a bit
    // still pending (SCL not yet fallen) is discounted when judging a truncated byte.
    assign frame_bad_s = (state_r == ACK) || (bit_cnt_r != {2'b00, bit_pend_r});

    // Decide which event, if any, the current cycle produces.
    always_comb begin
        ev_fire_s   = 1'b0;
        ev_kind_s   = EV_START;
        ev_byte_s   = 8'h00;
        ev_ack_s    = 1'b0;
        ev_first_s  = 1'b0;
        frame_set_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start_s) begin
                    ev_fire_s = 1'b1;
                    ev_kind_s = EV_START;
                end else begin
                    ev_fire_s = 1'b0;
                end
            end
            DATA, ACK: begin
                if (start_s) begin
                    ev_fire_s   = 1'b1;
                    ev_kind_s   = EV_RESTART;
                    frame_set_s = frame_bad_s;
                end else if (stop_s) begin
                    ev_fire_s   = 1'b1;
                    ev_kind_s   = EV_STOP;
                    frame_set_s = frame_bad_s;
                end else if (scl_rise_s && (state_r == ACK)) begin
                    ev_fire_s  = 1'b1;
                    ev_kind_s  = EV_BYTE;
                    ev_byte_s  = shreg_r;
                    ev_ack_s   = ~sda_f_s;
                    ev_first_s = first_r;
                end else begin
                    ev_fire_s = 1'b0;
                end
            end
            default: begin
                ev_fire_s = 1'b0;
            end
        endcase
    end

    // Decoder state machine, sticky flags and the event output register.
    always_ff @(posedge ICE_CLK) begin
        if (rst) begin
            scl_prev_r  <= 1'b1;
            sda_prev_r  <= 1'b1;
            state_r     <= IDLE;
            bit_cnt_r   <= 3'd0;
            bit_pend_r  <= 1'b0;
            shreg_r     <= 8'h00;
            first_r     <= 1'b0;
            busy_r      <= 1'b0;
            ev_valid_r  <= 1'b0;
            ev_type_r   <= EV_START;
            ev_data_r   <= 8'h00;
            ev_ack_r    <= 1'b0;
            ev_first_r  <= 1'b0;
            overflow_r  <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            scl_prev_r <= scl_f_s;
            sda_prev_r <= sda_f_s;

            case (state_r)
                IDLE: begin
                    if (start_s) begin
                        state_r    <= DATA;
                        bit_cnt_r  <= 3'd0;
                        bit_pend_r <= 1'b0;
                        first_r    <= 1'b1;
                        busy_r     <= 1'b1;
                    end
                end
                DATA, ACK: begin
                    if (start_s) begin
                        state_r    <= DATA;
                        bit_cnt_r  <= 3'd0;
                        bit_pend_r <= 1'b0;
                        first_r    <= 1'b1;
                    end else if (stop_s) begin
                        state_r    <= IDLE;
                        bit_pend_r <= 1'b0;
                        busy_r     <= 1'b0;
                    end else if (scl_rise_s && (state_r == DATA)) begin
                        shreg_r    <= {shreg_r[6:0], sda_f_s};
                        bit_pend_r <= 1'b1;
                        if (bit_cnt_r == 3'd7) begin
                            state_r <= ACK;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                        end
                    end else if (scl_rise_s) begin
                        state_r    <= DATA;
                        bit_cnt_r  <= 3'd0;
                        bit_pend_r <= 1'b0;
                        first_r    <= 1'b0;
                    end else if (scl_fall_s) begin
                        bit_pend_r <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase

            if (frame_set_s) begin
                frame_err_r <= 1'b1;
            end

            if (ev_fire_s) begin
                if (!ev_valid_r || bus.ev_ready) begin
                    ev_valid_r <= 1'b1;
                    ev_type_r  <= ev_kind_s;
                    ev_data_r  <= ev_byte_s;
                    ev_ack_r   <= ev_ack_s;
                    ev_first_r <= ev_first_s;
                end else begin
                    overflow_r <= 1'b1;
                end
            end else if (ev_valid_r && bus.ev_ready) begin
                ev_valid_r <= 1'b0;
            end
        end
    end

    assign bus.ev_valid  = ev_valid_r;
    assign bus.ev_type   = ev_type_r;
    assign bus.ev_data   = ev_data_r;
    assign bus.ev_ack    = ev_ack_r;
    assign bus.ev_first  = ev_first_r;
    assign bus.overflow  = overflow_r;
    assign bus.frame_err = frame_err_r;
    assign bus.busy      = busy_r;

endmodule

// File: doc/i2c_bus_sniffer.md
Name: i2c_bus_sniffer

Overview:
- Passive I2C decoder downstream of the I2C passthrough bridge.
- Taps the bridged SCL/SDA pins (raw pin inputs) and decodes bus traffic into a stream of START / RESTART / STOP / BYTE events.
- Events are emitted with a valid/ready handshake for a UART logger or LED debug logic.
- Never drives the bus.

Parameters:
- FILTER_LEN, 4: consecutive stable ICE_CLK cycles needed before a filtered line changes (1..15).
- CNT_W, 4: width of the filter counter.

Ports:
- ICE_CLK input 1: system clock.
- rst input 1: synchronous, active-high reset.
- scl_in input 1: raw SCL pin level, asynchronous.
- sda_in input 1: raw SDA pin level, asynchronous.
- ev_valid output 1: event available.
- ev_ready input 1: consumer accepts event.
- ev_type output 2: 0 START, 1 RESTART, 2 STOP, 3 BYTE.
- ev_data output 8: byte value, MSB first on wire; 0 for non-BYTE events.
- ev_ack output 1: ACK bit for BYTE (1 = ACK, i.e. SDA low); 0 otherwise.
- ev_first output 1: BYTE is the first byte after START/RESTART (address byte).
- overflow output 1: sticky, an event was dropped; cleared only by rst.
- frame_err output 1: sticky, STOP/RESTART arrived mid-byte; cleared only by rst.
- busy output 1: bus between START and STOP.

Behaviour:
- Clock and reset: one clock (ICE_CLK); reset is synchronous and active-high (rst). All logic is on the rising ICE_CLK edge.
- Reset values: ev_valid=0, ev_type=0, ev_data=0, ev_ack=0, ev_first=0, overflow=0, frame_err=0, busy=0. Filtered lines reset to 1 (idle bus). State=IDLE.
- Filter, per line:
  - 2-flop synchroniser, then a stable counter.
  - The filtered level takes the synchronised value once it has differed from the current filtered level for FILTER_LEN consecutive cycles.
  - Any bounce resets the counter.
- Edges: compare the filtered value with its previous-cycle copy.
  - START condition: SDA falls while SCL is high (SCL high in both cycles).
  - STOP condition: SDA rises while SCL is high.
  - Bit sample: SCL rising edge; capture the filtered SDA of that same cycle.
  - SCL and SDA changing in the same cycle: the SCL edge wins; no START/STOP is recognised.
- State machine (IDLE, DATA, ACK; bit_cnt 0..7):
  - IDLE: START → DATA, bit_cnt=0, first=1, emit START. SCL edges are ignored.
  - DATA: each SCL rise shifts SDA into shreg. When bit_cnt=7, go to ACK; otherwise bit_cnt++.
  - ACK: SCL rise → emit BYTE {shreg, ack=!sda, first}, clear first, go to DATA with bit_cnt=0.
  - START in DATA/ACK: emit RESTART, go to DATA, bit_cnt=0, first=1. If bit_cnt≠0 or the state is ACK, set frame_err.
  - STOP in any non-IDLE state: emit STOP, go to IDLE. Same frame_err rule as RESTART. STOP in IDLE is ignored.
- busy = (state ≠ IDLE).
- Output register:
  - ev_valid rises the cycle after the detecting cycle.
  - Fields are held stable while ev_valid && !ev_ready.
  - ev_valid drops the cycle after a handshake, unless a new event loads in that same cycle; in that case ev_valid stays 1 with the new fields.
  - Event generated while ev_valid && !ev_ready: the event is dropped, overflow=1, and the state machine still advances.
- End-to-end latency, pin edge to ev_valid: 2 (synchroniser) + FILTER_LEN + 1 cycles.
- Reset asserted mid-transfer: everything returns to reset values. The next START restarts decoding; no partial byte is emitted.

Decomposition:
- Package i2c_sniff_pkg holds EV_START=2'd0, EV_RESTART=2'd1, EV_STOP=2'd2, EV_BYTE=2'd3, and the state encodings IDLE/DATA/ACK.
- Sub-module i2c_line_filter (synchroniser + stable counter, parameter FILTER_LEN, reset output 1) is instantiated twice, once for SCL and once for SDA.

Test Plan:
1. Write 0x50 with ACK, then data 0xA5 with ACK, then STOP; ev_ready=1. Expect START; BYTE(0x50, ack=1, first=1); BYTE(0xA5, ack=1, first=0); STOP. busy goes 1→0. No error flags.
2. Write 0x51 with NACK, then restart and 0x3C, then STOP. Expect START, BYTE(0x51, ack=0, first=1), RESTART, BYTE(0x3C, first=1), STOP. frame_err=0.
3. STOP after 3 data bits. Expect START, then STOP with no BYTE; frame_err=1 and sticky; busy=0.
4. 2-cycle SDA glitch low while SCL is high, FILTER_LEN=4. Expect no event, busy stays 0. A 4-cycle low yields START.
5. Hold ev_ready=0 over START plus one byte. First START is held stable with ev_valid=1; BYTE is dropped and overflow=1. Raising ev_ready yields one handshake, then ev_valid=0.
6. Assert rst for 1 cycle after bit 4 of a byte. All outputs return to reset values. A following full transaction decodes correctly from START.
